// File: rtl/imm_gen_pipe_if.sv
`timescale 1ns/1ps
// Handshake bundle between fetch and execute for the immediate generator.
// Master drives instructions and out_ready; slave returns immediates, format and tag.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// Decode-stage immediate generator: RISC-V immediate + format code, tag carried alongside.
// Latency: 1 cycle from accept to out_valid when the output register is free.
// Backpressure: in_ready is registered (!skid valid); 2-entry OUT+skid keeps full throughput.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter bit CSR_UIMM = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  imm_gen_pipe_if.slave io
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  ent_t            dec_ent;

  ent_t out_q;
  ent_t sk_q;
  logic out_vld;
  logic sk_vld;
  logic out_free;
  logic accept;

  assign inst   = io.in_inst;
  assign opcode = inst[6:0];

  always_comb begin : fmt_decode
    dec_fmt = FMT_NONE;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FMT_I;
      // OP-IMM-32 only exists on RV64
      7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      7'b1110011: dec_fmt = (CSR_UIMM && inst[14]) ? FMT_Z : FMT_I;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111: dec_fmt = FMT_J;
      default:    dec_fmt = FMT_NONE;
    endcase
  end

  always_comb begin : imm_decode
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: dec_imm = XLEN'($signed(inst[31:20]));
      FMT_S: dec_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      FMT_B: dec_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_U: dec_imm = XLEN'($signed({inst[31:12], 12'b0}));
      FMT_J: dec_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      FMT_Z: dec_imm = XLEN'(inst[19:15]);
      default: dec_imm = '0;
    endcase
  end

  always_comb begin : ent_pack
    dec_ent     = '0;
    dec_ent.imm = dec_imm;
    dec_ent.fmt = dec_fmt;
    dec_ent.tag = io.in_tag;
  end

  // in_ready comes straight from the skid valid flop, never from out_ready
  assign out_free = io.out_ready || !out_vld;
  assign accept   = io.in_valid && !sk_vld;

  always_ff @(posedge clk) begin : buf_regs
    if (!rst_n) begin
      out_vld <= 1'b0;
      sk_vld  <= 1'b0;
      out_q   <= '0;
      sk_q    <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
      sk_vld  <= 1'b0;
    end else if (out_free) begin
      if (sk_vld) begin
        out_q   <= sk_q;
        out_vld <= 1'b1;
        sk_vld  <= 1'b0;
      end else begin
        out_vld <= accept;
        if (accept) begin
          out_q <= dec_ent;
        end
      end
    end else if (accept) begin
      sk_q   <= dec_ent;
      sk_vld <= 1'b1;
    end
  end

  assign io.in_ready  = !sk_vld;
  assign io.out_valid = out_vld;
  assign io.out_imm   = out_q.imm;
  assign io.out_fmt   = out_q.fmt;
  assign io.out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
// Bench for imm_gen_pipe: two instances (RV32 with zimm, RV64 without) fed identical stimulus,
// expected results queued on accept and compared on each output transfer.
module tb_imm_gen_pipe;
  localparam int NV = 14;

  typedef struct {
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [31:0] tag;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_inst   = '0;
  logic [31:0] in_tag    = '0;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  bit pat_en = 1'b0;
  int pat_i  = 0;

  exp_t q[$];
  exp_t cur_exp;

  bit          prev_stall = 1'b0;
  logic [31:0] prev_imm_a;
  logic [31:0] prev_tag_a;
  logic [2:0]  prev_fmt_a;
  logic [63:0] prev_imm_b;

  // inst, RV32+zimm result, RV64 without zimm result
  logic [31:0] v_inst  [NV] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h123450B7,
                               32'hFFDFF0EF, 32'hDEADBEFF, 32'h800000B7, 32'h0010009B,
                               32'h3401D073, 32'h34011073, 32'h7FF02083, 32'h00008067,
                               32'hFFFFF017, 32'h00209463};
  logic [31:0] v_imm_a [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
                               32'hFFFFFFFC, 32'h00000000, 32'h80000000, 32'h00000000,
                               32'h00000003, 32'h00000340, 32'h000007FF, 32'h00000000,
                               32'hFFFFF000, 32'h00000008};
  logic [2:0]  v_fmt_a [NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd4, 3'd0,
                               3'd6, 3'd1, 3'd1, 3'd1, 3'd4, 3'd3};
  logic [63:0] v_imm_b [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                               64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC, 64'h0,
                               64'hFFFFFFFF80000000, 64'h1, 64'h340, 64'h340, 64'h7FF, 64'h0,
                               64'hFFFFFFFFFFFFF000, 64'h8};
  logic [2:0]  v_fmt_b [NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd4, 3'd1,
                               3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd3};

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if_a ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_inst   = in_inst;
  assign if_a.in_tag    = in_tag;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_inst   = in_inst;
  assign if_b.in_tag    = in_tag;
  assign if_b.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CSR_UIMM(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (if_a.slave)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CSR_UIMM(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (if_b.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready pattern 1,0,0,1 repeating
  always @(posedge clk) begin
    #1;
    if (pat_en) begin
      out_ready = (pat_i == 0 || pat_i == 3);
      pat_i     = (pat_i + 1) % 4;
    end
  end

  // Scoreboard: occupancy, hold stability, ordered data compare
  always @(negedge clk) begin
    logic e_ov;
    logic e_ir;
    exp_t e;
    e_ov = (q.size() != 0);
    e_ir = (q.size() < 2);
    if (chk_en) begin
      n_vec++;
      if (if_a.out_valid !== e_ov || if_b.out_valid !== e_ov) begin
        n_err++;
        $display("FAIL occupancy_out_valid: dut_a=%b dut_b=%b required %b", if_a.out_valid, if_b.out_valid, e_ov);
      end
      n_vec++;
      if (if_a.in_ready !== e_ir || if_b.in_ready !== e_ir) begin
        n_err++;
        $display("FAIL skid_in_ready: dut_a=%b dut_b=%b required %b", if_a.in_ready, if_b.in_ready, e_ir);
      end
      if (prev_stall) begin
        n_vec++;
        if (if_a.out_valid !== 1'b1 || if_a.out_imm !== prev_imm_a || if_a.out_fmt !== prev_fmt_a ||
            if_a.out_tag !== prev_tag_a || if_b.out_imm !== prev_imm_b) begin
          n_err++;
          $display("FAIL hold_stable: got tag %h imm %h/%h required tag %h imm %h/%h",
                   if_a.out_tag, if_a.out_imm, if_b.out_imm, prev_tag_a, prev_imm_a, prev_imm_b);
        end
      end
    end
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (if_a.out_valid === 1'b1 && out_ready === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: tag %h appeared, required none", if_a.out_tag);
        end else begin
          e = q.pop_front();
          n_pop++;
          if (if_a.out_imm !== e.imm_a || if_a.out_fmt !== e.fmt_a || if_a.out_tag !== e.tag) begin
            n_err++;
            $display("FAIL data_rv32: got imm %h fmt %0d tag %h, required imm %h fmt %0d tag %h",
                     if_a.out_imm, if_a.out_fmt, if_a.out_tag, e.imm_a, e.fmt_a, e.tag);
          end
          n_vec++;
          if (if_b.out_imm !== e.imm_b || if_b.out_fmt !== e.fmt_b || if_b.out_tag !== e.tag) begin
            n_err++;
            $display("FAIL data_rv64: got imm %h fmt %0d tag %h, required imm %h fmt %0d tag %h",
                     if_b.out_imm, if_b.out_fmt, if_b.out_tag, e.imm_b, e.fmt_b, e.tag);
          end
        end
      end
      if (in_valid === 1'b1 && if_a.in_ready === 1'b1) q.push_back(cur_exp);
    end
    prev_stall = rst_n && !flush && (if_a.out_valid === 1'b1) && (out_ready === 1'b0);
    prev_imm_a = if_a.out_imm;
    prev_fmt_a = if_a.out_fmt;
    prev_tag_a = if_a.out_tag;
    prev_imm_b = if_b.out_imm;
  end

  task automatic push_item(input int idx, input logic [31:0] tag, output bit ok);
    bit got;
    got           = 1'b0;
    in_valid      = 1'b1;
    in_inst       = v_inst[idx];
    in_tag        = tag;
    cur_exp.imm_a = v_imm_a[idx];
    cur_exp.fmt_a = v_fmt_a[idx];
    cur_exp.imm_b = v_imm_b[idx];
    cur_exp.fmt_b = v_fmt_b[idx];
    cur_exp.tag   = tag;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (if_a.in_ready === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ok       = got;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_inst   = v_inst[0];
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1 || if_a.out_imm !== 32'h0 ||
        if_a.out_fmt !== 3'd0 || if_a.out_tag !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rv32: out_valid=%b in_ready=%b imm=%h fmt=%0d tag=%h, required 0 1 0 0 0",
               if_a.out_valid, if_a.in_ready, if_a.out_imm, if_a.out_fmt, if_a.out_tag);
    end
    n_vec++;
    if (if_b.out_valid !== 1'b0 || if_b.in_ready !== 1'b1 || if_b.out_imm !== 64'h0 ||
        if_b.out_fmt !== 3'd0 || if_b.out_tag !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rv64: out_valid=%b in_ready=%b imm=%h fmt=%0d tag=%h, required 0 1 0 0 0",
               if_b.out_valid, if_b.in_ready, if_b.out_imm, if_b.out_fmt, if_b.out_tag);
    end
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_decode();
    bit ok;
    out_ready = 1'b1;
    push_item(0, 32'h100, ok);
    @(negedge clk);
    n_vec++;
    if (!ok || if_a.out_valid !== 1'b1 || if_a.out_imm !== 32'hFFFFFFFF || if_a.out_fmt !== 3'd1) begin
      n_err++;
      $display("FAIL decode_addi_latency: accepted=%0d out_valid=%b imm=%h fmt=%0d, required 1 1 ffffffff 1",
               ok, if_a.out_valid, if_a.out_imm, if_a.out_fmt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_format_sweep();
    bit ok;
    out_ready = 1'b1;
    for (int i = 1; i < NV; i++) begin
      push_item(i, 32'h200 + i, ok);
      @(negedge clk);
      n_vec++;
      if (!ok || if_a.out_valid !== 1'b1 || if_a.out_tag !== 32'h200 + i) begin
        n_err++;
        $display("FAIL sweep_present_%0d: accepted=%0d out_valid=%b tag=%h, required 1 1 %h",
                 i, ok, if_a.out_valid, if_a.out_tag, 32'h200 + i);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      n_vec++;
      if (if_a.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL sweep_idle_%0d: out_valid=%b required 0", i, if_a.out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit all_ok;
    int c0;
    int c1;
    all_ok    = 1'b1;
    out_ready = 1'b1;
    c0        = cyc;
    for (int i = 0; i < NV; i++) begin
      push_item(i, 32'h300 + i, ok);
      all_ok &= ok;
    end
    c1 = cyc;
    n_vec++;
    if (!all_ok || (c1 - c0) != NV) begin
      n_err++;
      $display("FAIL b2b_throughput: %0d cycles for %0d items (all accepted=%0d), required %0d",
               c1 - c0, NV, all_ok, NV);
    end
    drain(ok);
    @(negedge clk);
    n_vec++;
    if (!ok || if_a.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: drained=%0d out_valid=%b, required 1 0", ok, if_a.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit all_ok;
    int p0;
    all_ok = 1'b1;
    p0     = n_pop;
    pat_i  = 0;
    pat_en = 1'b1;
    @(posedge clk);
    #2;
    for (int t = 1; t <= 8; t++) begin
      push_item((t - 1) % NV, t, ok);
      all_ok &= ok;
    end
    drain(ok);
    pat_en    = 1'b0;
    #1;
    out_ready = 1'b1;
    n_vec++;
    if (!all_ok || !ok || (n_pop - p0) != 8) begin
      n_err++;
      $display("FAIL backpressure_count: %0d outputs (accepted=%0d drained=%0d), required 8",
               n_pop - p0, all_ok, ok);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    bit ok1;
    bit ok2;
    bit ok3;
    int p0;
    out_ready = 1'b0;
    push_item(1, 32'hF01, ok1);
    push_item(2, 32'hF02, ok2);
    // OUT and skid both full; flush together with a new input
    in_valid = 1'b1;
    in_inst  = v_inst[3];
    in_tag   = 32'hF03;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (!ok1 || !ok2 || if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_full: out_valid=%b in_ready=%b (filled=%0d%0d), required 0 1",
               if_a.out_valid, if_a.in_ready, ok1, ok2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    // Only OUT full, in_ready high: input in the flush cycle is still dropped
    out_ready = 1'b0;
    push_item(4, 32'hF04, ok1);
    in_valid = 1'b1;
    in_inst  = v_inst[5];
    in_tag   = 32'hF05;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (!ok1 || if_a.out_valid !== 1'b0 || if_b.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drop_input: out_valid=%b/%b accepted=%0d, required 0/0 1",
               if_a.out_valid, if_b.out_valid, ok1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    p0 = n_pop;
    push_item(6, 32'hF06, ok1);
    drain(ok3);
    n_vec++;
    if (!ok1 || !ok3 || (n_pop - p0) != 1) begin
      n_err++;
      $display("FAIL flush_recover: %0d outputs after flush, required 1", n_pop - p0);
    end
  endtask

  task automatic test_reset_mid_stall();
    bit ok1;
    bit ok2;
    out_ready = 1'b0;
    push_item(7, 32'hA01, ok1);
    push_item(8, 32'hA02, ok2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (!ok1 || !ok2 || if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1 ||
        if_a.out_tag !== 32'h0 || if_b.out_imm !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid_stall: out_valid=%b in_ready=%b tag=%h imm64=%h, required 0 1 0 0",
               if_a.out_valid, if_a.in_ready, if_a.out_tag, if_b.out_imm);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_format_sweep();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
